// File: rtl/ddc_iq_acc_dump.sv
`default_nettype none
// ============================================================================
//  Module      : ddc_iq_acc_dump
//  Description : Decimating integrate-and-dump stage for one DDC channel.
//                Sums N consecutive signed I/Q mixer products per branch.
//                Rounds (half up) and saturates each frame sum to OUT_WIDTH.
//                Results are delivered through a 2-entry valid/ready buffer.
//  Ports       : clk          - single clock, rising edge
//                srst_n       - synchronous active-low reset
//                din_valid    - new mixer sample on din_i/din_q
//                din_i/din_q  - signed I/Q mixer products (IN_WIDTH)
//                dec_ratio    - decimation ratio N (0 treated as 1)
//                clr_overrun  - clears the sticky overrun flag
//                dout_valid   - output buffer head valid
//                dout_ready   - downstream accepts the head
//                dout_i/dout_q- signed rounded results (OUT_WIDTH)
//                overrun      - sticky: a result was dropped on a full buffer
//  Revision    : 1.0 - initial release
// ============================================================================
module ddc_iq_acc_dump #(
    parameter int IN_WIDTH  = 18,
    parameter int DEC_WIDTH = 8,
    parameter int ACC_WIDTH = 26,
    parameter int SHIFT     = 10,
    parameter int OUT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        srst_n,
    input  logic                        din_valid,
    input  logic signed [IN_WIDTH-1:0]  din_i,
    input  logic signed [IN_WIDTH-1:0]  din_q,
    input  logic        [DEC_WIDTH-1:0] dec_ratio,
    input  logic                        clr_overrun,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic signed [OUT_WIDTH-1:0] dout_i,
    output logic signed [OUT_WIDTH-1:0] dout_q,
    output logic                        overrun
);

    // One extra bit so the rounding offset can never wrap the frame sum.
    localparam int c_SUM_W   = ACC_WIDTH + 1;
    localparam int c_RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [c_SUM_W-1:0] c_RND =
        (SHIFT == 0) ? '0 : (c_SUM_W'(1) << c_RND_POS);
    localparam logic signed [c_SUM_W-1:0] c_MAX = c_SUM_W'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [c_SUM_W-1:0] c_MIN = ~c_MAX;

    // ------------------------------------------------------------------------
    // Round half up, then clamp to the signed OUT_WIDTH range.
    // ------------------------------------------------------------------------
    function automatic logic signed [OUT_WIDTH-1:0] f_round_sat(
        input logic signed [ACC_WIDTH-1:0] sum
    );
        logic signed [c_SUM_W-1:0] ext;
        logic signed [c_SUM_W-1:0] shifted;
        ext     = $signed({sum[ACC_WIDTH-1], sum}) + c_RND;
        shifted = ext >>> SHIFT;
        if (shifted > c_MAX) begin
            shifted = c_MAX;
        end else if (shifted < c_MIN) begin
            shifted = c_MIN;
        end
        return shifted[OUT_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Integrator
    // ------------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0]   r_acc_i;
    logic signed [ACC_WIDTH-1:0]   r_acc_q;
    logic        [DEC_WIDTH-1:0]   r_cnt;
    logic        [DEC_WIDTH-1:0]   r_ratio;
    logic                          r_rnd_valid;
    logic        [2*OUT_WIDTH-1:0] r_rnd_data;

    logic signed [ACC_WIDTH-1:0]   w_din_i_ext;
    logic signed [ACC_WIDTH-1:0]   w_din_q_ext;
    logic signed [ACC_WIDTH-1:0]   w_sum_i;
    logic signed [ACC_WIDTH-1:0]   w_sum_q;
    logic        [DEC_WIDTH-1:0]   w_ratio_eff;
    logic                          w_last;

    always_comb begin
        w_din_i_ext = {{(ACC_WIDTH-IN_WIDTH){din_i[IN_WIDTH-1]}}, din_i};
        w_din_q_ext = {{(ACC_WIDTH-IN_WIDTH){din_q[IN_WIDTH-1]}}, din_q};
        w_sum_i     = r_acc_i + w_din_i_ext;
        w_sum_q     = r_acc_q + w_din_q_ext;
        // The first sample of a frame already obeys the newly sampled ratio,
        // so the effective ratio is taken from dec_ratio while cnt is zero.
        if (r_cnt == '0) begin
            w_ratio_eff = (dec_ratio == '0) ? DEC_WIDTH'(1) : dec_ratio;
        end else begin
            w_ratio_eff = r_ratio;
        end
        w_last = (r_cnt == (w_ratio_eff - DEC_WIDTH'(1)));
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            r_cnt       <= '0;
            r_ratio     <= DEC_WIDTH'(1);
            r_rnd_valid <= 1'b0;
            r_rnd_data  <= '0;
        end else begin
            r_rnd_valid <= 1'b0;
            if (din_valid) begin
                r_ratio <= w_ratio_eff;
                if (w_last) begin
                    r_acc_i     <= '0;
                    r_acc_q     <= '0;
                    r_cnt       <= '0;
                    r_rnd_valid <= 1'b1;
                    r_rnd_data  <= {f_round_sat(w_sum_i), f_round_sat(w_sum_q)};
                end else begin
                    r_acc_i <= w_sum_i;
                    r_acc_q <= w_sum_q;
                    r_cnt   <= r_cnt + DEC_WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // 2-entry output buffer. r_buf0 is always the head and drives the outputs,
    // so the outputs keep the last popped value while the buffer is empty.
    // ------------------------------------------------------------------------
    logic [1:0]             r_count;
    logic [2*OUT_WIDTH-1:0] r_buf0;
    logic [2*OUT_WIDTH-1:0] r_buf1;
    logic                   r_overrun;
    logic                   w_pop;
    logic                   w_drop;

    always_comb begin
        w_pop  = (r_count != 2'd0) && dout_ready;
        w_drop = r_rnd_valid && (r_count == 2'd2) && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_count   <= 2'd0;
            r_buf0    <= '0;
            r_buf1    <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (r_rnd_valid) begin
                        r_buf0  <= r_rnd_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (r_rnd_valid && w_pop) begin
                        r_buf0 <= r_rnd_data;
                    end else if (r_rnd_valid) begin
                        r_buf1  <= r_rnd_data;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    // Full: a write only fits when the head leaves this cycle.
                    if (w_pop) begin
                        r_buf0 <= r_buf1;
                        if (r_rnd_valid) begin
                            r_buf1 <= r_rnd_data;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
            endcase

            // A drop wins over a simultaneous clear.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign dout_valid = (r_count != 2'd0);
    assign dout_i     = r_buf0[2*OUT_WIDTH-1:OUT_WIDTH];
    assign dout_q     = r_buf0[OUT_WIDTH-1:0];
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
